// File: rtl/bcd_out_pkg.sv
// bcd_out_pkg: state encoding, display codes and segment glyphs for bcd_out.
package bcd_out_pkg;
    typedef enum logic {S_IDLE, S_CONV} state_t;
    localparam logic [3:0] NEGATIVE = 4'hA;
    localparam logic [3:0] OFF      = 4'hF;
    localparam logic [3:0] BLANK    = 4'hF;
    // Active-low {g,f,e,d,c,b,a}; code 4'hA is the minus sign, 4'hB..4'hF are dark.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0111111,
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
endpackage

// File: rtl/bcd_out_seg7_enc.sv
// seg7_enc: 4-bit digit/sign code to active-low seven-segment drive.
module seg7_enc
    import bcd_out_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);
    always_comb o_seg = SEG_TABLE[i_code];
endmodule

// File: rtl/bcd_out.sv
// bcd_out: signed binary to sign + 3-digit BCD via sequential double-dabble.
// Define BCD_OUT_SEG_EN to add registered seven-segment outputs.
module bcd_out
    import bcd_out_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_ones_value,
    output logic [3:0]       o_tens_value,
    output logic [3:0]       o_huns_value,
    output logic [3:0]       o_sign,
    output logic             o_sign_mode,
    output logic             o_ovf
`ifdef BCD_OUT_SEG_EN
    ,
    output logic [6:0]       o_seg_ones,
    output logic [6:0]       o_seg_tens,
    output logic [6:0]       o_seg_huns,
    output logic [6:0]       o_seg_sign
`endif
);
    localparam int SW = 16;
    localparam int CW = $clog2(WIDTH);

    function automatic logic [SW+WIDTH-1:0] dd_step(input logic [SW-1:0] s, input logic [WIDTH-1:0] m);
        logic [SW-1:0] a;
        for (int i = 0; i < SW / 4; i++)
            a[4*i +: 4] = s[4*i +: 4] >= 4'd5 ? s[4*i +: 4] + 4'd3 : s[4*i +: 4];
        return {a[SW-2:0], m, 1'b0};
    endfunction

    state_t           r_state;
    logic [SW-1:0]    r_scr;
    logic [WIDTH-1:0] r_mag;
    logic [CW-1:0]    r_cnt;
    logic             r_neg, r_busy, r_done, r_sign_mode, r_ovf;
    logic [3:0]       r_ones, r_tens, r_huns, r_sign;

    logic [WIDTH-1:0]    w_mag;
    logic [SW+WIDTH-1:0] w_first, w_next;
    logic [SW-1:0]       w_scr;
    logic                w_ovf;
    logic [3:0]          w_ones, w_tens, w_huns, w_sign;

    // The first iteration runs while loading so done lands WIDTH cycles after start.
    always_comb begin
        w_mag   = i_value[WIDTH-1] ? -i_value : i_value;
        w_first = dd_step('0, w_mag);
        w_next  = dd_step(r_scr, r_mag);
        w_scr   = w_next[SW+WIDTH-1:WIDTH];
        w_ovf   = |w_scr[15:12];
        w_huns  = w_ovf ? BLANK : w_scr[11:8];
        w_tens  = w_ovf ? BLANK : w_scr[7:4];
        w_ones  = w_ovf ? BLANK : w_scr[3:0];
        w_sign  = r_neg ? NEGATIVE : OFF;
    end

`ifdef BCD_OUT_SEG_EN
    logic [6:0] w_seg_ones, w_seg_tens, w_seg_huns, w_seg_sign;
    logic [6:0] r_seg_ones, r_seg_tens, r_seg_huns, r_seg_sign;
    seg7_enc u_enc_ones (.i_code(w_ones), .o_seg(w_seg_ones));
    seg7_enc u_enc_tens (.i_code(w_tens), .o_seg(w_seg_tens));
    seg7_enc u_enc_huns (.i_code(w_huns), .o_seg(w_seg_huns));
    seg7_enc u_enc_sign (.i_code(w_sign), .o_seg(w_seg_sign));
    assign o_seg_ones = r_seg_ones;
    assign o_seg_tens = r_seg_tens;
    assign o_seg_huns = r_seg_huns;
    assign o_seg_sign = r_seg_sign;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_scr       <= '0;
            r_mag       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ones      <= 4'd0;
            r_tens      <= 4'd0;
            r_huns      <= 4'd0;
            r_sign      <= OFF;
            r_sign_mode <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef BCD_OUT_SEG_EN
            r_seg_ones  <= SEG_TABLE[0];
            r_seg_tens  <= SEG_TABLE[0];
            r_seg_huns  <= SEG_TABLE[0];
            r_seg_sign  <= SEG_TABLE[OFF];
`endif
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_state        <= S_CONV;
                r_busy         <= 1'b1;
                {r_scr, r_mag} <= w_first;
                r_cnt          <= CW'(1);
                r_neg          <= i_value[WIDTH-1];
            end
        end else if (r_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            {r_scr, r_mag} <= w_next;
            r_cnt          <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_done      <= 1'b1;
                r_ones      <= w_ones;
                r_tens      <= w_tens;
                r_huns      <= w_huns;
                r_sign      <= w_sign;
                r_sign_mode <= r_neg;
                r_ovf       <= w_ovf;
`ifdef BCD_OUT_SEG_EN
                r_seg_ones  <= w_seg_ones;
                r_seg_tens  <= w_seg_tens;
                r_seg_huns  <= w_seg_huns;
                r_seg_sign  <= w_seg_sign;
`endif
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_ones_value = r_ones;
    assign o_tens_value = r_tens;
    assign o_huns_value = r_huns;
    assign o_sign       = r_sign;
    assign o_sign_mode  = r_sign_mode;
    assign o_ovf        = r_ovf;
endmodule
